// File: rtl/gemv_engine.sv
// gemv_engine: streamed signed fixed-point matrix-vector product y = W*x (+ b), one saturated row per strobe
// Optional bias word per row when GEMV_BIAS_EN is defined (row stride becomes IN_LEN+1).
module gemv_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int IN_LEN  = 16,
  parameter int OUT_LEN = 32,
  parameter int ADDR_W  = 27,
  parameter int ACC_W   = 40
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       vec_wr_en,
  input  logic [$clog2(IN_LEN)-1:0]  vec_wr_idx,
  input  logic [DATA_W-1:0]          vec_wr_data,
  output logic                       rd_req,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic                       rd_ack,
  input  logic                       rd_valid,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       out_valid,
  output logic [$clog2(OUT_LEN)-1:0] out_idx,
  output logic [DATA_W-1:0]          out_data,
  output logic                       busy,
  output logic                       done
);
  localparam int IW = $clog2(IN_LEN);
  localparam int OW = $clog2(OUT_LEN);
  localparam int CW = $clog2(IN_LEN + 1);
  localparam int PW = 2 * DATA_W;
`ifdef GEMV_BIAS_EN
  localparam int LAST_C = IN_LEN;
`else
  localparam int LAST_C = IN_LEN - 1;
`endif
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE} state_t;
  state_t                    r_state, w_next;
  logic [ADDR_W-1:0]         r_addr;
  logic [OW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_vec [IN_LEN];
  logic                      w_col_last, w_row_last, w_is_bias, w_vec_ok, w_fits;
  logic signed [DATA_W-1:0]  w_x;
  logic signed [PW-1:0]      w_prod;
  logic signed [ACC_W-1:0]   w_term, w_shift;
  logic [ACC_W-DATA_W:0]     w_top;
  logic [DATA_W-1:0]         w_sat;
  assign w_col_last = r_col == CW'(LAST_C);
  assign w_row_last = r_row == OW'(OUT_LEN - 1);
`ifdef GEMV_BIAS_EN
  assign w_is_bias = r_col == CW'(IN_LEN);
`else
  assign w_is_bias = 1'b0;
`endif
  assign w_vec_ok = {1'b0, vec_wr_idx} < (IW + 1)'(IN_LEN);
  assign w_x      = r_vec[r_col[IW-1:0]];
  assign w_prod   = $signed(rd_data) * w_x;
  // bias words carry the same scale as x, so they line up with products after a FRAC_W shift
  assign w_term   = w_is_bias ? (ACC_W'($signed(rd_data)) <<< FRAC_W) : ACC_W'(w_prod);
  assign w_shift  = r_acc >>> FRAC_W;
  assign w_top    = w_shift[ACC_W-1:DATA_W-1];
  assign w_fits   = (&w_top) | ~(|w_top);
  assign w_sat    = w_fits ? w_shift[DATA_W-1:0] : {w_shift[ACC_W-1], {(DATA_W-1){~w_shift[ACC_W-1]}}};
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_next;
  // next-state: one outstanding read per column, emit after the last column of a row
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_REQ : S_IDLE;
      S_REQ:   w_next = rd_ack ? S_WAIT : S_REQ;
      S_WAIT:  w_next = rd_valid ? (w_col_last ? S_EMIT : S_REQ) : S_WAIT;
      S_EMIT:  w_next = w_row_last ? S_DONE : S_REQ;
      default: w_next = S_IDLE;
    endcase
  end
  // datapath: vector file, running read address, counters and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_acc  <= '0;
      for (int i = 0; i < IN_LEN; i++) r_vec[i] <= '0;
    end else begin
      if (r_state == S_IDLE && vec_wr_en && w_vec_ok) r_vec[vec_wr_idx] <= vec_wr_data;
      if (r_state == S_IDLE && start) begin
        r_addr <= base_addr;
        r_row  <= '0;
        r_col  <= '0;
        r_acc  <= '0;
      end
      if (r_state == S_REQ && rd_ack) r_addr <= r_addr + 1'b1;
      if (r_state == S_WAIT && rd_valid) begin
        r_acc <= r_acc + w_term;
        if (!w_col_last) r_col <= r_col + 1'b1;
      end
      if (r_state == S_EMIT) begin
        r_acc <= '0;
        r_col <= '0;
        if (!w_row_last) r_row <= r_row + 1'b1;
      end
    end
  end
  // outputs decoded from state and registers
  always_comb begin
    rd_req    = r_state == S_REQ;
    rd_addr   = r_addr;
    out_valid = r_state == S_EMIT;
    out_idx   = r_row;
    out_data  = w_sat;
    busy      = r_state != S_IDLE;
    done      = r_state == S_DONE;
  end
endmodule

// File: tb/tb_gemv_engine.sv
// tb_gemv_engine: directed checks of gemv_engine with IN_LEN=4, OUT_LEN=2 and a zero-wait memory
module tb_gemv_engine;
`ifdef GEMV_BIAS_EN
  localparam int S = 5;
  localparam logic [15:0] B0 = 16'h0100;
  localparam logic [15:0] E0 = 16'h0380;
`else
  localparam int S = 4;
  localparam logic [15:0] B0 = 16'h0000;
  localparam logic [15:0] E0 = 16'h0280;
`endif
  localparam int C = 2 * S + 1;
  logic        clk = 0, reset = 1, start = 0, vec_wr_en = 0;
  logic [26:0] base_addr = '0;
  logic [1:0]  vec_wr_idx = '0;
  logic [15:0] vec_wr_data = '0;
  logic        rd_req, rd_ack, rd_valid, out_valid, busy, done;
  logic [26:0] rd_addr;
  logic [15:0] rd_data, out_data, rd_q;
  logic        out_idx, rv_q = 0, ack_block = 0, stray_v = 0;
  logic [15:0] mem [512];
  int total = 0, bad = 0;
  int nout, nlog, done_cyc, hold_bad;
  int gc [2];
  logic [15:0] gd [2];
  logic        gi [2];
  logic [26:0] alog [16];
  gemv_engine #(.IN_LEN(4), .OUT_LEN(2)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .vec_wr_en(vec_wr_en), .vec_wr_idx(vec_wr_idx), .vec_wr_data(vec_wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  assign rd_ack   = rd_req & ~ack_block;
  assign rd_valid = rv_q | stray_v;
  assign rd_data  = stray_v ? 16'h7FFF : rd_q;
  always @(posedge clk) begin
    rv_q <= reset ? 1'b0 : (rd_req & rd_ack);
    rd_q <= mem[rd_addr[8:0]];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wx(input logic [1:0] idx, input logic [15:0] d);
    @(negedge clk);
    vec_wr_en = 1; vec_wr_idx = idx; vec_wr_data = d;
    @(negedge clk);
    vec_wr_en = 0;
  endtask
  task automatic load_x(input logic [15:0] a, b, c, d);
    wx(0, a); wx(1, b); wx(2, c); wx(3, d);
  endtask
  task automatic fill(input int base, input logic [15:0] w0, w1, b);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < S; c++)
        mem[base + r * S + c] = (c < 4) ? (r == 0 ? w0 : w1) : (r == 0 ? b : 16'h0000);
  endtask
  task automatic run(input logic [26:0] base, input int hold_from, stray_at, poke_at, rst_at);
    logic [26:0] hold_addr;
    nout = 0; nlog = 0; done_cyc = -1; hold_bad = 0; hold_addr = '0;
    gc[0] = -1; gc[1] = -1; gd[0] = 'x; gd[1] = 'x; gi[0] = 1'bx; gi[1] = 1'bx;
    @(negedge clk);
    base_addr = base; start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int n = 1; n < 300; n++) begin
      @(negedge clk);
      ack_block = hold_from > 0 && n >= hold_from && n < hold_from + 5;
      stray_v = n == stray_at;
      start = n == poke_at;
      vec_wr_en = n == poke_at; vec_wr_idx = 0; vec_wr_data = 16'h7FFF;
      if (n == hold_from) hold_addr = rd_addr;
      if (ack_block && (!rd_req || rd_addr !== hold_addr)) hold_bad++;
      if (out_valid && nout < 2) begin
        gd[nout] = out_data; gi[nout] = out_idx; gc[nout] = n; nout++;
      end
      if (rd_req && rd_ack && nlog < 16) begin
        alog[nlog] = rd_addr; nlog++;
      end
      if (done) begin
        done_cyc = n;
        break;
      end
      if (n == rst_at) begin
        reset = 1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        reset = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (done || out_valid || busy) hold_bad++;
        end
        check("rst_quiet", hold_bad, 0);
        break;
      end
    end
    ack_block = 0; stray_v = 0; start = 0; vec_wr_en = 0;
    if (rst_at == 0) check("timeout", done_cyc > 0, 1);
  endtask
  task automatic rows(input logic [15:0] e0, e1, input int shift);
    check("nout", nout, 2);
    check("r0_data", gd[0], e0);
    check("r0_idx", gi[0], 0);
    check("r0_cyc", gc[0], C + shift);
    check("r1_data", gd[1], e1);
    check("r1_idx", gi[1], 1);
    check("r1_cyc", gc[1], 2 * C + shift);
    check("done_cyc", done_cyc, 2 * C + 1 + shift);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst0_busy", busy, 0);
    check("rst0_rd_req", rd_req, 0);
    check("rst0_out_valid", out_valid, 0);
    check("rst0_done", done, 0);
    check("rst0_rd_addr", rd_addr, 0);
    check("rst0_out_idx", out_idx, 0);
    check("rst0_out_data", out_data, 0);
    reset = 0;
    load_x(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    fill(16'h100, 16'h0100, 16'h0080, B0);
    run(27'h100, 0, 0, 0, 0);
    rows(E0, 16'h0140, 0);
    check("n_req", nlog, 2 * S);
    for (int i = 0; i < 2 * S; i++) check("addr_seq", alog[i], 27'h100 + 27'(i));
    load_x(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    fill(0, 16'h7FFF, 16'h7FFF, 16'h0000);
    run(27'h0, 0, 0, 0, 0);
    rows(16'h7FFF, 16'h7FFF, 0);
    fill(0, 16'h8000, 16'h8000, 16'h0000);
    run(27'h0, 0, 0, 0, 0);
    rows(16'h8000, 16'h8000, 0);
    load_x(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    run(27'h100, 3, 5, 0, 0);
    rows(E0, 16'h0140, 5);
    check("hold_stable", hold_bad, 0);
    run(27'h100, 0, 0, 0, C + 3);
    check("rst_rows_seen", nout, 1);
    load_x(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    run(27'h100, 0, 0, 0, 0);
    rows(E0, 16'h0140, 0);
    run(27'h100, 0, 0, 2, 0);
    rows(E0, 16'h0140, 0);
    run(27'h100, 0, 0, 0, 0);
    rows(E0, 16'h0140, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
